// File: rtl/cordic_pkg.sv
// Shared constants for the CORDIC vectoring wrapper: widths, atan ROM, gain terms,
// byte-FSM state encoding and the shift-add gain helper.
package cordic_pkg;

  localparam int ITER  = 16;
  localparam int IN_W  = 16;
  localparam int GUARD = 4;                   // fractional guard bits below the input LSB
  localparam int XY_W  = IN_W + 2 + GUARD;    // sign + gain growth + guard
  localparam int PH_W  = 32;
  localparam int ACC_W = XY_W + 17;

  localparam logic [PH_W-1:0] PI = 32'h8000_0000;

  // round(atan(2^-i) * 2^31 / pi)
  // NOTE: constant ROM, so there is nothing to reset; only registers holding run state are cleared.
  localparam logic [PH_W-1:0] ATAN [ITER] = '{
    32'h2000_0000, 32'h12E4_051E, 32'h09FB_385B, 32'h0511_11D4,
    32'h028B_0D43, 32'h0145_D7E1, 32'h00A2_F61E, 32'h0051_7C55,
    32'h0028_BE53, 32'h0014_5F2F, 32'h000A_2F98, 32'h0005_17CC,
    32'h0002_8BE6, 32'h0001_45F3, 32'h0000_A2FA, 32'h0000_517D
  };

  // K = 2^-1 + 2^-3 - 2^-6 - 2^-9 - 2^-13 - 2^-15 - 2^-16 = 0.6072540
  localparam int K_TERMS = 7;
  localparam int K_SHIFT [K_TERMS] = '{1, 3, 6, 9, 13, 15, 16};
  localparam bit K_NEG   [K_TERMS] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_CALC  = 2'd1,
    ST_SCALE = 2'd2,
    ST_SEND  = 2'd3
  } state_t;

  // Terms are accumulated 16 bits up so the per-term truncation does not stack up.
  function automatic logic [15:0] scale_mag(input logic signed [XY_W-1:0] x);
    logic signed [ACC_W-1:0] xe;
    logic signed [ACC_W-1:0] acc;
    xe  = ACC_W'(x);
    acc = '0;
    for (int k = 0; k < K_TERMS; k++) begin
      if (K_NEG[k]) acc = acc - (xe <<< (16 - K_SHIFT[k]));
      else          acc = acc + (xe <<< (16 - K_SHIFT[k]));
    end
    if (acc[ACC_W-1])                   return 16'h0000;
    else if (|acc[ACC_W-1:16+GUARD+16]) return 16'hFFFF;
    else                                return acc[16+GUARD+15:16+GUARD];
  endfunction

endpackage

// File: rtl/cordic_vectoring_core.sv
// Vectoring CORDIC: half-plane pre-rotation on start, one micro-rotation per clock,
// then a single shift-add gain correction cycle that raises done.
module cordic_vectoring_core
  import cordic_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ena,
  input  logic                   start,
  input  logic signed [IN_W-1:0] x_in,
  input  logic signed [IN_W-1:0] y_in,
  output logic                   calc_last,
  output logic                   done,
  output logic [15:0]            mag,
  output logic [PH_W-1:0]        phase
);

  logic signed [XY_W-1:0] x_q, y_q;
  logic [PH_W-1:0]        z_q;
  logic [3:0]             iter_q;
  logic                   busy_q, scale_q, zero_q;
  logic [15:0]            mag_q;

  logic signed [XY_W-1:0] x_ext, y_ext, x_pre, y_pre;
  logic [PH_W-1:0]        z_pre;
  logic signed [XY_W-1:0] x_sh, y_sh, x_nx, y_nx;
  logic [PH_W-1:0]        z_nx;

  // Left half-plane inputs are mirrored through the origin; +pi and -pi share one
  // encoding in a 32-bit binary angle, so the start phase is PI either way.
  always_comb begin
    // NOTE: every output gets a default before any branch so no path holds a value, which would infer a latch.
    x_ext = XY_W'(x_in) <<< GUARD;
    y_ext = XY_W'(y_in) <<< GUARD;
    x_pre = x_ext;
    y_pre = y_ext;
    z_pre = '0;
    if (x_in[IN_W-1]) begin
      x_pre = -x_ext;
      y_pre = -y_ext;
      z_pre = PI;
    end
  end

  always_comb begin
    x_sh = x_q >>> iter_q;
    y_sh = y_q >>> iter_q;
    x_nx = x_q + y_sh;
    y_nx = y_q - x_sh;
    z_nx = z_q + ATAN[iter_q];
    if (y_q[XY_W-1]) begin
      x_nx = x_q - y_sh;
      y_nx = y_q + x_sh;
      z_nx = z_q - ATAN[iter_q];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      iter_q  <= '0;
      busy_q  <= 1'b0;
      scale_q <= 1'b0;
      zero_q  <= 1'b0;
      mag_q   <= '0;
    end else if (ena) begin
      // NOTE: non-blocking assignments make every register sample pre-edge values; blocking ones would chain updates within one edge.
      if (start) begin
        x_q     <= x_pre;
        y_q     <= y_pre;
        z_q     <= z_pre;
        zero_q  <= (x_in == '0) && (y_in == '0);
        iter_q  <= '0;
        busy_q  <= 1'b1;
        scale_q <= 1'b0;
      end else if (busy_q) begin
        x_q    <= x_nx;
        y_q    <= y_nx;
        z_q    <= z_nx;
        iter_q <= iter_q + 4'd1;
        if (iter_q == 4'(ITER-1)) begin
          busy_q  <= 1'b0;
          scale_q <= 1'b1;
        end
      end else if (scale_q) begin
        mag_q   <= scale_mag(x_q);
        scale_q <= 1'b0;
      end
    end
  end

  assign calc_last = busy_q && (iter_q == 4'(ITER-1));
  assign done      = scale_q;
  assign mag       = mag_q;
  // The origin has no defined angle; report zero instead of the accumulated sum.
  assign phase     = zero_q ? '0 : z_q;

endmodule

// File: rtl/cordic_wrapper.sv
// Byte-serial wrapper around the vectoring core: collects X/Y over a valid/ready
// input channel and returns magnitude and phase as six bytes on the output channel.
module cordic_wrapper
  import cordic_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  state_t          state_q, state_d;
  logic [1:0]      in_cnt_q;
  logic [2:0]      out_idx_q;
  logic [7:0]      x_lo_q, x_hi_q, y_lo_q;
  logic [7:0]      out_byte_q;
  logic            in_ready_q, out_valid_q;

  logic            in_valid, out_ready, in_fire, out_fire, start;
  logic            calc_last, done;
  logic [15:0]     mag;
  logic [PH_W-1:0] phase;
  logic [2:0]      send_idx;
  logic [7:0]      byte_sel;
  logic            unused_uio;

  assign in_valid   = uio_in[0];
  assign out_ready  = uio_in[3];
  assign unused_uio = ^{uio_in[7:4], uio_in[2:1]};

  assign in_fire  = ena && in_valid && in_ready_q;
  assign out_fire = ena && out_valid_q && out_ready;
  assign start    = in_fire && (in_cnt_q == 2'd3);

  cordic_vectoring_core u_core (
    .clk       (clk),
    .rst       (rst),
    .ena       (ena),
    .start     (start),
    .x_in      ({x_hi_q, x_lo_q}),
    .y_in      ({ui_in, y_lo_q}),
    .calc_last (calc_last),
    .done      (done),
    .mag       (mag),
    .phase     (phase)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_LOAD:  if (start)     state_d = ST_CALC;
      ST_CALC:  if (calc_last) state_d = ST_SCALE;
      ST_SCALE: if (done)      state_d = ST_SEND;
      ST_SEND:  if (out_fire && (out_idx_q == 3'd5)) state_d = ST_LOAD;
      default:                 state_d = ST_LOAD;
    endcase
  end

  // The output register is primed with byte 0, then reloaded with the next byte on each transfer.
  assign send_idx = out_valid_q ? out_idx_q + 3'd1 : out_idx_q;

  always_comb begin
    case (send_idx)
      3'd0:    byte_sel = mag[7:0];
      3'd1:    byte_sel = mag[15:8];
      3'd2:    byte_sel = phase[7:0];
      3'd3:    byte_sel = phase[15:8];
      3'd4:    byte_sel = phase[23:16];
      3'd5:    byte_sel = phase[31:24];
      default: byte_sel = 8'h00;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_LOAD;
      in_cnt_q    <= '0;
      out_idx_q   <= '0;
      x_lo_q      <= '0;
      x_hi_q      <= '0;
      y_lo_q      <= '0;
      out_byte_q  <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (ena) begin
      state_q    <= state_d;
      in_ready_q <= (state_d == ST_LOAD);
      if (in_fire) begin
        in_cnt_q <= in_cnt_q + 2'd1;
        case (in_cnt_q)
          2'd0:    x_lo_q <= ui_in;
          2'd1:    x_hi_q <= ui_in;
          2'd2:    y_lo_q <= ui_in;
          default: ;
        endcase
      end
      if (state_q == ST_SEND) begin
        if (!out_valid_q) begin
          out_byte_q  <= byte_sel;
          out_valid_q <= 1'b1;
        end else if (out_fire) begin
          if (out_idx_q == 3'd5) begin
            out_idx_q   <= '0;
            out_byte_q  <= '0;
            out_valid_q <= 1'b0;
          end else begin
            out_idx_q  <= out_idx_q + 3'd1;
            out_byte_q <= byte_sel;
          end
        end
      end
    end
  end

  assign uo_out  = out_valid_q ? out_byte_q : 8'h00;
  assign uio_out = {5'b0, out_valid_q, in_ready_q, 1'b0};
  assign uio_oe  = 8'b0000_0110;

endmodule

// File: tb/tb_cordic_wrapper.sv
// Self-checking bench for cordic_wrapper: directed corner frames, stalls, resets and
// random frames compared against a real-arithmetic magnitude/atan2 reference.
module tb_cordic_wrapper;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ena = 1'b1;
  logic [7:0] ui_in = '0;
  logic [7:0] uio_in = '0;
  logic [7:0] uo_out, uio_out, uio_oe;

  int checks = 0;
  int errors = 0;

  localparam real PI_R = 3.14159265358979323846;

  cordic_wrapper dut (
    .clk     (clk),
    .rst     (rst),
    .ena     (ena),
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  always #5 clk = ~clk;

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Modular distance, so phases near +/-pi compare correctly.
  task automatic check_near(input string tag, input logic [31:0] obs, input logic [31:0] exp,
                            input int tol);
    logic [31:0] d;
    int          sd;
    d  = obs - exp;
    sd = $signed(d);
    if (sd < 0) sd = -sd;
    checks++;
    assert (sd <= tol) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (tol %0d)", tag, obs, exp, tol);
    end
  endtask

  // Reference: true vector length and atan2 scaled to a 32-bit binary angle.
  task automatic ref_model(input logic [15:0] x, input logic [15:0] y,
                           output logic [31:0] mag_e, output logic [31:0] ph_e);
    int     xi, yi;
    real    xr, yr, a;
    longint p;
    xi = $signed(x);
    yi = $signed(y);
    xr = real'(xi);
    yr = real'(yi);
    mag_e = 32'(longint'($floor($sqrt(xr * xr + yr * yr))));
    a = $atan2(yr, xr);
    p = longint'(a / PI_R * 2147483648.0);
    ph_e = p[31:0];
  endtask

  task automatic push_byte(input logic [7:0] b);
    int n;
    n = 0;
    ui_in     = b;
    uio_in[0] = 1'b1;
    while (uio_out[1] !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("push_ready_timeout", 32'(n < 100), 32'd1);
    @(posedge clk);
    #1;
    uio_in[0] = 1'b0;
  endtask

  task automatic push_frame(input logic [15:0] x, input logic [15:0] y);
    push_byte(x[7:0]);
    push_byte(x[15:8]);
    push_byte(y[7:0]);
    push_byte(y[15:8]);
  endtask

  task automatic run_frame(input logic [15:0] x, input logic [15:0] y,
                           input int stall0, input int freeze_at);
    logic [7:0]  got [6];
    logic [7:0]  first;
    logic [31:0] mag_e, ph_e;
    int          pre, gap;
    pre = 0;
    push_frame(x, y);
    if (freeze_at > 0) begin
      repeat (freeze_at) @(posedge clk);
      #1;
      ena = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      check("freeze_no_valid", 32'(uio_out), 32'h00);
      ena = 1'b1;
      pre = freeze_at;
    end
    repeat (17 - pre) @(posedge clk);
    #1;
    check("latency_17_idle", 32'(uio_out), 32'h00);
    @(posedge clk);
    #1;
    check("latency_18_valid", 32'(uio_out), 32'h04);
    if (stall0 > 0) begin
      first = uo_out;
      repeat (stall0) @(posedge clk);
      #1;
      check("stall_hold", 32'(uo_out), 32'(first));
      check("stall_valid", 32'(uio_out[2]), 32'd1);
    end
    for (int i = 0; i < 6; i++) begin
      gap = $urandom_range(0, 2);
      uio_in[3] = 1'b0;
      repeat (gap) @(posedge clk);
      #1;
      check("send_valid", 32'(uio_out[2]), 32'd1);
      got[i]    = uo_out;
      uio_in[3] = 1'b1;
      @(posedge clk);
      #1;
    end
    uio_in[3] = 1'b0;
    check("back_to_load", 32'({uo_out, uio_out}), 32'h0002);
    ref_model(x, y, mag_e, ph_e);
    check_near("mag", 32'({got[1], got[0]}), mag_e, 4);
    check_near("phase", {got[5], got[4], got[3], got[2]}, ph_e, 1 << 19);
  endtask

  task automatic abort_run(input int wait_edges);
    push_frame(16'h1234, 16'h2345);
    repeat (wait_edges) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("abort_rst_outputs", 32'({uo_out, uio_out}), 32'h0000);
    @(negedge clk);
    rst = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    check("abort_no_output", 32'({uo_out, uio_out}), 32'h0002);
  endtask

  initial begin
    logic [15:0] rx, ry;
    longint      m2;

    #12;
    check("rst_uo_out", 32'(uo_out), 32'h00);
    check("rst_uio_out", 32'(uio_out), 32'h00);
    check("uio_oe", 32'(uio_oe), 32'h06);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("ready_before_edge", 32'(uio_out[1]), 32'd0);
    @(posedge clk);
    #1;
    check("ready_after_edge", 32'(uio_out[1]), 32'd1);

    run_frame(16'h3524, 16'h5E81, 50, 0);
    run_frame(16'h4000, 16'h0000, 0, 0);
    run_frame(16'h0000, 16'hC000, 0, 5);
    run_frame(16'h8000, 16'h0000, 3, 0);
    run_frame(16'h0000, 16'h0000, 0, 0);
    run_frame(16'h8000, 16'h8000, 0, 0);

    // Partial frame discarded by reset; only the next frame may come out.
    push_byte(8'hAA);
    push_byte(8'h55);
    #2;
    rst = 1'b1;
    #1;
    check("partial_rst_outputs", 32'({uo_out, uio_out}), 32'h0000);
    @(negedge clk);
    rst = 1'b0;
    run_frame(16'h4000, 16'h4000, 0, 0);

    abort_run(8);
    abort_run(20);

    for (int f = 0; f < 16; f++) begin
      do begin
        rx = 16'($urandom);
        ry = 16'($urandom);
        m2 = longint'($signed(rx)) * longint'($signed(rx))
           + longint'($signed(ry)) * longint'($signed(ry));
      end while (m2 < 64'd4194304);
      run_frame(rx, ry, $urandom_range(0, 4), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cordic_wrapper.md
CORDIC_WRAPPER -- requirements
Module: cordic_wrapper

Interface
REQ-001 Ports SHALL be one clock and one reset: reset is asynchronous and active-high.
REQ-002 clk  input  1  rising-edge system clock.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 ena  input  1  enable; 0 = hold all state, no transfers.
REQ-005 ui_in  input  8  input data byte.
REQ-006 uo_out  output  8  output data byte; valid while out_valid=1, else 0x00.
REQ-007 uio_in  input  8  bit0 = in_valid, bit3 = out_ready; other bits ignored.
REQ-008 uio_out  output  8  bit1 = in_ready, bit2 = out_valid; other bits 0.
REQ-009 uio_oe  output  8  constant 8'b0000_0110.

Function
REQ-010 A transfer SHALL occur on a rising clk edge only when ena=1 and valid=1 and ready=1 on the same channel.
REQ-011 Input order SHALL be 4 bytes: X[7:0], X[15:8], Y[7:0], Y[15:8]; X and Y are 16-bit two's complement.
REQ-012 States SHALL be LOAD -> CALC -> SCALE -> SEND -> LOAD.
REQ-013 LOAD: in_ready=1, out_valid=0; a 2-bit byte counter advances per input transfer; the 4th transfer enters CALC.
REQ-014 CALC/SCALE/SEND: in_ready=0; in_valid is ignored.
REQ-015 CALC SHALL pre-rotate into the right half-plane (X<0: negate X and Y, phase start +pi if Y>=0, else -pi); it SHALL then run 16 vectoring iterations, one per clk.
REQ-016 Datapath width SHALL be at least 18 bits signed for X/Y; X=-32768 SHALL NOT overflow.
REQ-017 Phase SHALL be a 32-bit signed binary angle, 2^31 = pi rad, range [-pi, pi); the atan table holds round(atan(2^-i)*2^31/pi), i=0..15.
REQ-018 SCALE (1 clk) SHALL compute magnitude = final X times K = 0.607253 using a shift-add constant; the result is truncated to 16-bit unsigned and saturates at 0xFFFF.
REQ-019 Result accuracy SHALL be |mag error| <= 4 LSB and |phase error| <= 2^19 counts (~0.05 deg).
REQ-020 SEND SHALL present 6 bytes in order: mag[7:0], mag[15:8], ph[7:0], ph[15:8], ph[23:16], ph[31:24].
REQ-021 In SEND, out_valid=1; uo_out SHALL hold stable until its transfer; the index advances per transfer; the 6th transfer returns to LOAD with in_ready=1 on the next cycle.
REQ-022 out_ready held low SHALL stall SEND indefinitely without data loss.
REQ-023 The first out_valid SHALL occur exactly 18 clk after the 4th input transfer (16 CALC + 1 SCALE + 1 register).
REQ-024 X=Y=0 SHALL yield mag=0x0000 and phase=0x00000000.
REQ-025 ena=0 SHALL freeze state, counters and datapath; outputs keep their values.

Reset
REQ-026 rst=1 SHALL asynchronously force LOAD and clear the byte counter, the output index, X/Y/phase registers and the magnitude.
REQ-027 During reset, uo_out=0x00, in_ready=0 and out_valid=0; in_ready rises on the first clk after release.
REQ-028 Reset asserted mid-CALC or mid-SEND SHALL discard the operation; no partial output follows.

Structure
REQ-029 Package cordic_pkg SHALL hold: ITER=16, the 32-bit atan table, the gain K shift terms, the state enum, and PI = 32'h8000_0000.
REQ-030 Sub-module cordic_vectoring_core SHALL hold pre-rotation, iterations and scaling with start/done; the top holds the byte FSM and TT pin mapping.
REQ-031 Implementation SHALL be 120-400 RTL lines with no multipliers or dividers.

Verification
REQ-032 Input X=0x3524, Y=0x5E81 -> bytes 0x6C,0x6C (+/-4 on mag), phase ~0x2B1D_4C00 +/-2^19.
REQ-033 Input X=0x4000, Y=0x0000 -> mag 0x4000 +/-4, phase 0x00000000 +/-2^19.
REQ-034 Input X=0x0000, Y=0xC000 -> mag 0x4000 +/-4, phase ~0xC000_0000 (-pi/2).
REQ-035 Input X=0x8000, Y=0x0000 -> mag 0x8000 +/-4, phase ~0x8000_0000 (-pi) with no overflow.
REQ-036 Hold out_ready=0 for 50 clk after out_valid -> uo_out stable at the mag LSB; all 6 bytes correct afterward.
REQ-037 Assert rst after 2 input bytes, then send a full frame -> the result corresponds to the new frame only.
